// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer stimulus controller.
// LFSR seed/width and the ms-counter width live here so sub-blocks agree.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    REACT = 2'd2
  } state_t;

  localparam int          LFSR_W    = 7;
  localparam logic [6:0]  LFSR_SEED = 7'h01;
  localparam int          MS_W      = 12;

  // Fibonacci step for x^7+x^6+1; shifts left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[6] ^ cur[5]};
  endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 7-bit maximal-length LFSR; reseeds synchronously on rst.
// The seed is non-zero and the polynomial is primitive, so the all-zero lock-up state is unreachable.
module reaction_lfsr
  import reaction_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/reaction_stimulus_ctrl.sv
// Reaction-timer initiator: lights LEDs for a pseudo-random delay, then pulses
// start_counting; a reaction or timeout ends the trial with an end_counting pulse.
module reaction_stimulus_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_PER_MS   = 50000,
  parameter int unsigned MIN_DELAY_MS = 250,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter int unsigned LED_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 react,
  output logic                 start_counting,
  output logic                 end_counting,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 busy,
  output logic                 false_start,
  output logic                 timeout
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [MS_W-1:0]   dcnt;
  logic [MS_W-1:0]   mscnt;
  logic [LFSR_W-1:0] lfsr;
  logic [MS_W-1:0]   delay_d;
  logic              tick;

  reaction_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign tick    = (presc == PW'(CLK_PER_MS - 1));
  assign delay_d = MS_W'(MIN_DELAY_MS) + MS_W'({lfsr, 4'b0000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      presc          <= '0;
      dcnt           <= '0;
      mscnt          <= '0;
      start_counting <= 1'b0;
      end_counting   <= 1'b0;
      leds           <= '0;
      busy           <= 1'b0;
      false_start    <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      start_counting <= 1'b0;
      end_counting   <= 1'b0;
      case (state)
        IDLE: begin
          presc <= '0;
          if (trigger) begin
            state       <= DELAY;
            dcnt        <= delay_d;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            leds        <= '1;
            busy        <= 1'b1;
          end
        end
        DELAY: begin
          presc <= tick ? '0 : presc + PW'(1);
          // A reaction on the terminal tick still counts as jumping the gun.
          if (react) begin
            state       <= IDLE;
            false_start <= 1'b1;
            leds        <= '0;
            busy        <= 1'b0;
          end else if (tick) begin
            if (dcnt == MS_W'(1)) begin
              state          <= REACT;
              leds           <= '0;
              start_counting <= 1'b1;
              mscnt          <= '0;
              presc          <= '0;
            end else begin
              dcnt <= dcnt - MS_W'(1);
            end
          end
        end
        REACT: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (react) begin
            state        <= IDLE;
            end_counting <= 1'b1;
            busy         <= 1'b0;
          end else if (tick) begin
            if (mscnt == MS_W'(TIMEOUT_MS - 1)) begin
              state        <= IDLE;
              end_counting <= 1'b1;
              timeout      <= 1'b1;
              busy         <= 1'b0;
            end else begin
              mscnt <= mscnt + MS_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          leds  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_stimulus_ctrl.sv
// Scoreboard bench for reaction_stimulus_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and checks them as start/end pulses appear.
module tb_reaction_stimulus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic       react;
  logic       start_counting;
  logic       end_counting;
  logic [9:0] leds;
  logic       busy;
  logic       false_start;
  logic       timeout;

  typedef struct {
    bit is_end;
    int cyc;
    bit to;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         errors  = 0;
  int         cyc     = 0;
  logic [6:0] lfsr_m;

  reaction_stimulus_ctrl #(
    .CLK_PER_MS   (4),
    .MIN_DELAY_MS (2),
    .TIMEOUT_MS   (5),
    .LED_WIDTH    (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trigger        (trigger),
    .react          (react),
    .start_counting (start_counting),
    .end_counting   (end_counting),
    .leds           (leds),
    .busy           (busy),
    .false_start    (false_start),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  // Edge counter and reference LFSR, both advanced on the DUT's active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) lfsr_m <= 7'h01;
    else     lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_state(input string name, input logic [9:0] l, input logic b,
                           input logic fs, input logic to);
    chk({name, ".leds"}, 32'(leds), 32'(l));
    chk({name, ".busy"}, 32'(busy), 32'(b));
    chk({name, ".false_start"}, 32'(false_start), 32'(fs));
    chk({name, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic push(input bit is_end, input int c, input bit to);
    exp_t e;
    e.is_end = is_end;
    e.cyc    = c;
    e.to     = to;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issues a one-cycle trigger; returns its sampling edge and the predicted start edge.
  task automatic fire(output int e0, output int s);
    e0 = cyc + 1;
    s  = e0 + 4 * (2 + 16 * int'(lfsr_m));
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic summary;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
  endtask

  always @(negedge clk) begin
    if (start_counting || end_counting) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_pulse: start=%0b end=%0b at edge %0d, expected none",
                 start_counting, end_counting, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_exclusive", 32'(start_counting && end_counting), 32'd0);
        chk("pulse_kind_end", 32'(end_counting), 32'(e.is_end));
        chk("pulse_edge", 32'(cyc), 32'(e.cyc));
        chk("pulse_timeout", 32'(timeout), 32'(e.to));
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: stimulus did not finish by edge %0d", cyc);
    summary();
    $finish;
  end

  initial begin
    int e0, s;
    rst = 1'b1; trigger = 1'b0; react = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("reset", 10'h000, 1'b0, 1'b0, 1'b0);
    chk("reset.start", 32'(start_counting), 32'd0);
    chk("reset.end", 32'(end_counting), 32'd0);
    chk("reset.lfsr", 32'(dut.lfsr), 32'h01);
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
      @(negedge clk);
      chk_state("idle_react", 10'h000, 1'b0, 1'b0, 1'b0);
    end

    // Trial with seed LFSR: D = 2 + 16 = 18 ms -> 72 clocks; react 10 clocks after start.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
    push(1'b0, e0 + 72, 1'b0);
    push(1'b1, e0 + 72 + 11, 1'b0);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk_state("delay", 10'h3FF, 1'b1, 1'b0, 1'b0);
    wait_until(e0 + 71);
    chk("pre_start.leds", 32'(leds), 32'h3FF);
    wait_until(e0 + 72);
    chk_state("start", 10'h000, 1'b1, 1'b0, 1'b0);
    wait_until(e0 + 82);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk_state("reacted", 10'h000, 1'b0, 1'b0, 1'b0);

    // False start 20 clocks into DELAY; flag is sticky until the next trigger.
    repeat (3) @(negedge clk);
    fire(e0, s);
    wait_until(e0 + 19);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk_state("false_start", 10'h000, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("false_start_sticky", 32'(false_start), 32'd1);

    // No reaction: timeout 20 clocks after start.
    fire(e0, s);
    chk("fs_cleared", 32'(false_start), 32'd0);
    push(1'b0, s, 1'b0);
    push(1'b1, s + 20, 1'b1);
    wait_until(s + 20);
    chk_state("timeout", 10'h000, 1'b0, 1'b0, 1'b1);

    // Reset 5 clocks into REACT: abort without end_counting.
    repeat (2) @(negedge clk);
    fire(e0, s);
    chk("to_cleared", 32'(timeout), 32'd0);
    push(1'b0, s, 1'b0);
    wait_until(s + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_state("rst_in_react", 10'h000, 1'b0, 1'b0, 1'b0);
    chk("rst_in_react.lfsr", 32'(dut.lfsr), 32'h01);
    repeat (30) @(negedge clk);

    // Second trigger during DELAY must not reload the delay.
    fire(e0, s);
    push(1'b0, s, 1'b0);
    push(1'b1, s + 3, 1'b0);
    wait_until(e0 + 9);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk_state("retrigger", 10'h3FF, 1'b1, 1'b0, 1'b0);
    wait_until(s + 2);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;

    // React on the terminal DELAY tick is a false start.
    repeat (2) @(negedge clk);
    fire(e0, s);
    wait_until(s - 1);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk_state("fs_terminal", 10'h000, 1'b0, 1'b1, 1'b0);

    // React on the timeout tick is a normal reaction.
    repeat (2) @(negedge clk);
    fire(e0, s);
    push(1'b0, s, 1'b0);
    push(1'b1, s + 20, 1'b0);
    wait_until(s + 19);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk_state("react_on_timeout", 10'h000, 1'b0, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
